// File: rtl/edge_event_arbiter.sv
// Rising-edge detector on N event lines with per-channel pending latches,
// drained round-robin onto a single registered valid/ready event port.
module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    x,
  input  logic [N-1:0]    en,
  input  logic            evt_ready,
  input  logic            ovr_clr,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overrun
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    prev_q, prev_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    overrun_q, overrun_d;
  logic            evt_valid_q, evt_valid_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N-1:0]    edge_v;
  logic [N-1:0]    accept_v;
  logic            accept;
  logic [ID_W-1:0] win_hi, win_lo, winner;
  logic            hit_hi;

  assign accept = (state_q == GRANT) && evt_ready;

  always_comb begin
    edge_v   = x & ~prev_q & en;
    prev_d   = x;
    accept_v = '0;
    for (int i = 0; i < N; i++)
      accept_v[i] = accept && (evt_id_q == ID_W'(i));
    // A fresh edge on the channel being accepted re-arms it rather than overrunning.
    pending_d = (pending_q & ~accept_v) | edge_v;
    overrun_d = (ovr_clr ? '0 : overrun_q) | (edge_v & pending_q & ~accept_v);
  end

  // Lowest pending index at or above rr_ptr, else lowest pending index overall.
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    hit_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) win_lo = ID_W'(i);
      if (pending_q[i] && (ID_W'(i) >= rr_ptr_q)) begin
        win_hi = ID_W'(i);
        hit_hi = 1'b1;
      end
    end
    winner = hit_hi ? win_hi : win_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending_q) state_d = GRANT;
      GRANT:   if (evt_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          evt_valid_d = 1'b1;
          evt_id_d    = winner;
        end
      end
      GRANT: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          rr_ptr_d    = (evt_id_q == ID_W'(N - 1)) ? '0 : evt_id_q + ID_W'(1);
        end
      end
      default: evt_valid_d = 1'b0;
    endcase
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: a 4-channel instance for most steps
// and a 3-channel instance for the round-robin wrap case.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x, en;
  logic       rdy, clr;
  logic       v;
  logic [1:0] id;
  logic [3:0] pend, ovr;

  logic [2:0] x3, en3;
  logic       rdy3, clr3;
  logic       v3;
  logic [1:0] id3;
  logic [2:0] pend3, ovr3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.N(4), .ID_W(2)) u_dut (
    .clk(clk), .rst(rst), .x(x), .en(en), .evt_ready(rdy), .ovr_clr(clr),
    .evt_valid(v), .evt_id(id), .pending(pend), .overrun(ovr)
  );

  edge_event_arbiter #(.N(3), .ID_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .x(x3), .en(en3), .evt_ready(rdy3), .ovr_clr(clr3),
    .evt_valid(v3), .evt_id(id3), .pending(pend3), .overrun(ovr3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; x = '0; en = 4'hF; rdy = 1'b0; clr = 1'b0;
    x3 = '0; en3 = 3'h7; rdy3 = 1'b0; clr3 = 1'b0;

    // reset state
    tick();
    chk("rst_valid", 32'(v), 32'h0);
    chk("rst_id", 32'(id), 32'h0);
    chk("rst_pending", 32'(pend), 32'h0);
    chk("rst_overrun", 32'(ovr), 32'h0);

    // 1: single held-high line -> exactly one event
    rst = 1'b0; x = 4'b0001; rdy = 1'b1;
    tick();
    chk("t1_pend_c1", 32'(pend), 32'h1);
    chk("t1_valid_c1", 32'(v), 32'h0);
    tick();
    chk("t1_valid_c2", 32'(v), 32'h1);
    chk("t1_id_c2", 32'(id), 32'h0);
    tick();
    chk("t1_valid_acc", 32'(v), 32'h0);
    chk("t1_pend_acc", 32'(pend), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_no_more", 32'(v), 32'h0);
    end

    // 2: all four rise together from a fresh reset -> 0,1,2,3 with idle gaps
    rst = 1'b1; x = '0;
    tick();
    rst = 1'b0; x = 4'hF;
    tick();
    chk("t2_pend_all", 32'(pend), 32'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_valid", 32'(v), 32'h1);
      chk("t2_id", 32'(id), 32'(k));
      tick();
      chk("t2_gap", 32'(v), 32'h0);
      chk("t2_pend", 32'(pend), 32'((4'hF << (k + 1)) & 4'hF));
    end

    // 3: overrun while stalled, ovr_clr, then a single delivery
    x = '0; rdy = 1'b0;
    tick();
    x = 4'b0100;
    tick();
    x = '0;
    tick();
    chk("t3_valid", 32'(v), 32'h1);
    chk("t3_id", 32'(id), 32'h2);
    x = 4'b0100;
    tick();
    chk("t3_ovr_set", 32'(ovr), 32'h4);
    chk("t3_id_stable", 32'(id), 32'h2);
    x = '0; clr = 1'b1;
    tick();
    chk("t3_ovr_clr", 32'(ovr), 32'h0);
    chk("t3_still_valid", 32'(v), 32'h1);
    clr = 1'b0; rdy = 1'b1;
    tick();
    chk("t3_acc_valid", 32'(v), 32'h0);
    chk("t3_acc_pend", 32'(pend), 32'h0);
    tick();
    chk("t3_single", 32'(v), 32'h0);

    // 5: accept of ch1 coincides with a new ch1 edge
    rdy = 1'b0; x = 4'b0010;
    tick();
    x = '0;
    tick();
    chk("t5_id1", 32'(id), 32'h1);
    chk("t5_valid1", 32'(v), 32'h1);
    rdy = 1'b1; x = 4'b0010;
    tick();
    chk("t5_pend_kept", 32'(pend), 32'h2);
    chk("t5_no_ovr", 32'(ovr), 32'h0);
    chk("t5_gap", 32'(v), 32'h0);
    x = '0;
    tick();
    chk("t5_second_valid", 32'(v), 32'h1);
    chk("t5_second_id", 32'(id), 32'h1);
    tick();
    chk("t5_drained", 32'(pend), 32'h0);

    // 6a: disabled channel ignores its edges
    en = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      x = 4'b1000;
      tick();
      x = '0;
      tick();
      chk("t6_en_pend", 32'(pend), 32'h0);
      chk("t6_en_valid", 32'(v), 32'h0);
    end

    // 6b: reset during GRANT discards everything
    en = 4'hF; rdy = 1'b0; x = 4'b0101;
    tick();
    x = '0;
    tick();
    chk("t6_grant_valid", 32'(v), 32'h1);
    x = 4'b0001;
    tick();
    chk("t6_ovr_pre", 32'(ovr), 32'h1);
    x = '0; rst = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(v), 32'h0);
    chk("t6_rst_pend", 32'(pend), 32'h0);
    chk("t6_rst_ovr", 32'(ovr), 32'h0);
    rst = 1'b0;
    tick();
    chk("t6_post_valid", 32'(v), 32'h0);

    // 4: N=3 wrap from rr_ptr=2
    x3 = 3'b010;
    tick();
    x3 = '0;
    tick();
    chk("t4_id1", 32'(id3), 32'h1);
    x3 = 3'b101; rdy3 = 1'b1;
    tick();
    chk("t4_pend", 32'(pend3), 32'h5);
    chk("t4_gap", 32'(v3), 32'h0);
    x3 = '0;
    tick();
    chk("t4_first_id2", 32'(id3), 32'h2);
    chk("t4_first_valid", 32'(v3), 32'h1);
    tick();
    chk("t4_pend_after2", 32'(pend3), 32'h1);
    tick();
    chk("t4_wrap_id0", 32'(id3), 32'h0);
    chk("t4_wrap_valid", 32'(v3), 32'h1);
    tick();
    chk("t4_drained", 32'(pend3), 32'h0);
    x3 = 3'b111;
    tick();
    tick();
    chk("t4_rr_at1", 32'(id3), 32'h1);
    chk("t4_rr_valid", 32'(v3), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
